// File: rtl/mem_responder_if.sv
// mem_responder_if
// Request/response bundle between the CPU memory controller (master) and
// the memory responder (slave).
//   req_valid/req_ready : request handshake, transfer on a rising edge with both high
//   req_write           : 1 = store, 0 = fetch/load
//   req_addr            : byte address
//   req_wdata/req_be    : store data and per-byte enables
//   resp_valid          : one-cycle completion pulse
//   resp_rdata/resp_err : read word and error flag, held until the next response
//   busy                : responder is working on a request
interface mem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
// Unified instruction/data memory slave for the multi-cycle RV32 CPU.
// Accepts one request at a time, waits WAIT_CYCLES, performs a byte-enabled
// write or full-word read on the ACCESS edge and pulses resp_valid for one
// cycle afterwards.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (array contents are not reset)
//   bus   : mem_responder_if slave modport (request/response handshake)
// Parameters:
//   DEPTH_WORDS : number of 32-bit words, word index = req_addr[31:2]
//   WAIT_CYCLES : wait states between acceptance and array access (0..15)
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_responder_if.slave bus
);
    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_U   = DEPTH_WORDS;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t             r_state;
    state_t             w_state_next;

    // Request captured at acceptance; only the word index is kept since
    // the error flag already encodes everything the upper bits mean.
    logic               r_write;
    logic [IDX_W-1:0]   r_idx;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be;
    logic               r_err;
    logic [3:0]         r_cnt;

    // r_rd_sel gates the lane read registers onto resp_rdata, so writes,
    // errors and reset all present zero without touching the RAM outputs.
    logic               r_rd_sel;
    logic               r_resp_err;

    logic               w_accept;
    logic               w_req_err;
    logic               w_mem_we;
    logic               w_mem_re;
    logic [31:0]        w_rd_word;

    assign w_accept  = (r_state == S_IDLE) && bus.req_valid;
    assign w_req_err = (bus.req_addr[1:0] != 2'b00) ||
                       ({2'b00, bus.req_addr[31:2]} >= DEPTH_U);
    assign w_mem_we  = (r_state == S_ACCESS) &&  r_write && !r_err;
    assign w_mem_re  = (r_state == S_ACCESS) && !r_write && !r_err;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_state_next = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_ACCESS;
                end
            end
            S_ACCESS: w_state_next = S_RESP;
            S_RESP:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.busy       = 1'b1;
        bus.resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
            end
            S_RESP:  bus.resp_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.resp_rdata = r_rd_sel ? w_rd_word : 32'd0;
    assign bus.resp_err   = r_resp_err;

    // ---------------- request registers, wait counter, response flags ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write    <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= 32'd0;
            r_be       <= 4'd0;
            r_err      <= 1'b0;
            r_cnt      <= 4'd0;
            r_rd_sel   <= 1'b0;
            r_resp_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= bus.req_write;
                r_idx   <= bus.req_addr[IDX_W+1:2];
                r_wdata <= bus.req_wdata;
                r_be    <= bus.req_be;
                r_err   <= w_req_err;
                r_cnt   <= WAIT_LOAD;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (r_state == S_ACCESS) begin
                r_rd_sel   <= !r_write && !r_err;
                r_resp_err <= r_err;
            end
        end
    end

    // ---------------- storage: one byte-wide RAM per lane ----------------
    // Separate lane arrays give each byte enable its own write port and a
    // registered read, which maps cleanly onto block RAM byte-write modes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH_WORDS];
            logic [7:0] r_rd_byte;

            always_ff @(posedge clk) begin
                if (w_mem_we && r_be[gi]) begin
                    r_mem[r_idx] <= r_wdata[8*gi +: 8];
                end
                if (w_mem_re) begin
                    r_rd_byte <= r_mem[r_idx];
                end
            end

            assign w_rd_word[8*gi +: 8] = r_rd_byte;
        end
    endgenerate
endmodule

// File: doc/mem_responder.md
# mem_responder

Unified instruction/data memory slave for the multi-cycle RV32 CPU. It sits opposite the main controller's fetch, load and store states. It accepts one request at a time over a valid/ready handshake and models a configurable number of wait states. It performs byte-enabled writes or full-word reads and returns a one-cycle response pulse with read data and an error flag.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words stored; word index = req_addr[31:2].
- WAIT_CYCLES, 2: wait states inserted between acceptance and array access; legal range 0..15.
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- req_valid  input  1  request present; held stable by the CPU until accepted.
- req_write  input  1  1 = store, 0 = read (fetch or load).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, byte lanes aligned to address bits [1:0]=0.
- req_be  input  4  store byte enables; bit i writes bits [8i+7:8i]; ignored on reads.
- req_ready  output  1  high only in IDLE; a transfer occurs on a rising edge with req_valid && req_ready.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  read word; 0 for writes and errors; held until the next response.
- resp_err  output  1  request was misaligned or out of range; valid with resp_valid, held like resp_rdata.
- busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE: req_ready=1. On acceptance, register addr, write, wdata and be into request registers. Compute err = (addr[1:0]!=0) || (addr[31:2] >= DEPTH_WORDS) and register it.
  - If WAIT_CYCLES=0, go to ACCESS.
  - Otherwise load the 4-bit counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT: decrement the counter each cycle. Go to ACCESS when counter==0, so WAIT lasts exactly WAIT_CYCLES cycles.
- ACCESS: the array operation takes effect on the edge leaving ACCESS. Next state is RESP.
  - Write, no error: update only the enabled bytes. be=4'b0000 is legal and changes nothing. resp_rdata<=0.
  - Read, no error: resp_rdata<=mem[index].
  - Error: no array change. resp_rdata<=0, resp_err<=1.
  - Non-error transfers clear resp_err.
- RESP: resp_valid=1 for exactly this cycle, then IDLE. req_ready=0, so a request already present is accepted on the first edge of IDLE.
- Array contents are not affected by rst. Simulation initial contents are all zero.
- Reset (rst=0) at any time forces IDLE, counter=0, resp_valid=0, resp_rdata=0 and resp_err=0. A request not yet past its ACCESS edge is discarded with no array change and no response.

## Timing
- Reset values: req_ready=1 (IDLE), busy=0, resp_valid=0, resp_rdata=0, resp_err=0.
- Latency: for acceptance on edge E0, the ACCESS edge is E0+WAIT_CYCLES+1. resp_valid is high in the cycle after edge E0+WAIT_CYCLES+1 and low again after E0+WAIT_CYCLES+2.
- Throughput: one transfer per WAIT_CYCLES+3 cycles when req_valid is held continuously.
- Read data is registered; no combinational path runs from req_* to resp_*.
- req_valid while busy has no effect. Request inputs may change freely after acceptance.
- Request registers and the counter are unaffected by inputs outside IDLE.

## Test plan
- Reset, then write with WAIT_CYCLES=2: addr 0x10, wdata 0xDEADBEEF, be 4'hF accepted at E0 -> resp_valid high in the cycle after E3, resp_err=0, resp_rdata=0. Read of 0x10 then returns 0xDEADBEEF.
- Byte enables: word 0x20=0x11223344, write wdata 0xAABBCCDD with be 4'b0101 -> subsequent read returns 0x11BB33DD.
- Errors: read 0x22 -> resp_err=1, resp_rdata=0. Write to byte address 4*DEPTH_WORDS -> resp_err=1, and a read of word 0 is unchanged. A following good read clears resp_err.
- WAIT_CYCLES=0 build: read accepted at E0 -> resp_valid high in the cycle after E1. With req_valid held high continuously, acceptances occur every 3 cycles.
- Busy blocking: assert a second request one cycle after acceptance and hold it -> req_ready=0 and busy=1 through RESP. The second request is accepted on the first edge of IDLE, and the first response carries the first request's data.
- Reset mid-operation: write 0x5555AAAA to 0x40 (prior 0x0), drop rst during WAIT -> no resp_valid, all outputs at reset values, and a later read of 0x40 returns 0x0.
